// File: rtl/fnd_scan_ctrl.sv
// Four-digit multiplexed display controller: captures a 14-bit binary value,
// converts it to BCD by serial double-dabble and scans the digits out one per slot.
module fnd_scan_ctrl #(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [13:0] i_value,
  input  logic        i_load,
  input  logic        i_blank_en,
  output logic [3:0]  o_bcd,
  output logic [3:0]  o_com,
  output logic        o_busy,
  output logic        o_done
);

  localparam int unsigned DIV_W = $clog2(SCAN_DIV);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q,   state_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [13:0]        shift_q,   shift_d;
  logic [15:0]        bcd_q,     bcd_d;
  logic [15:0]        disp_q,    disp_d;
  logic [DIV_W-1:0]   div_q,     div_d;
  logic [1:0]         idx_q,     idx_d;
  logic [3:0]         bcd_out_q, bcd_out_d;
  logic [3:0]         com_q,     com_d;
  logic               busy_q,    busy_d;
  logic               done_q,    done_d;
  logic [15:0]        bcd_adj_s;
  logic [15:0]        bcd_next_s;
  logic [3:0]         digit_s;
  logic               blank_s;

  function automatic logic [3:0] add3(input logic [3:0] d);
    logic [3:0] r;
    if (d >= 4'd5) begin
      r = d + 4'd3;
    end else begin
      r = d;
    end
    return r;
  endfunction

  // Conversion FSM: next state, working registers and the display latch.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    disp_d     = disp_q;
    bcd_adj_s  = {add3(bcd_q[15:12]), add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};
    bcd_next_s = {bcd_adj_s[14:0], shift_q[13]};
    case (state_q)
      S_IDLE: begin
        if (i_load) begin
          shift_d   = (i_value > 14'd9999) ? 14'd9999 : i_value;
          bcd_d     = 16'd0;
          bit_cnt_d = 4'd0;
          state_d   = S_CONV;
        end else begin
          state_d   = S_IDLE;
        end
      end
      S_CONV: begin
        bcd_d     = bcd_next_s;
        shift_d   = {shift_q[12:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 4'd1;
        // The final shift result goes straight to the display so it lands with DONE.
        if (bit_cnt_q == 4'd13) begin
          disp_d  = bcd_next_s;
          state_d = S_DONE;
        end else begin
          state_d = S_CONV;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  // Scan divider, slot index and the registered digit/common outputs.
  always_comb begin
    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      div_d = div_q + DIV_W'(1);
      idx_d = idx_q;
    end
    digit_s = disp_d[{idx_d, 2'b00} +: 4];
    case (idx_d)
      2'd1:    blank_s = i_blank_en && (disp_d[15:4]  == 12'd0);
      2'd2:    blank_s = i_blank_en && (disp_d[15:8]  == 8'd0);
      2'd3:    blank_s = i_blank_en && (disp_d[15:12] == 4'd0);
      default: blank_s = 1'b0;
    endcase
    if (blank_s) begin
      com_d     = 4'b1111;
      bcd_out_d = 4'd0;
    end else begin
      com_d     = ~(4'b0001 << idx_d);
      bcd_out_d = digit_s;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 4'd0;
      shift_q   <= 14'd0;
      bcd_q     <= 16'd0;
      disp_q    <= 16'd0;
      div_q     <= '0;
      idx_q     <= 2'd0;
      bcd_out_q <= 4'd0;
      com_q     <= 4'b1111;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      disp_q    <= disp_d;
      div_q     <= div_d;
      idx_q     <= idx_d;
      bcd_out_q <= bcd_out_d;
      com_q     <= com_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_bcd  = bcd_out_q;
  assign o_com  = com_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: doc/fnd_scan_ctrl.md
FND_SCAN_CTRL -- requirements
Module: fnd_scan_ctrl

Interface
REQ-001 The block SHALL have parameter SCAN_DIV, default 100000, giving the clock cycles each digit stays enabled (1 kHz digit rate at 100 MHz); legal range 2 to 2^20.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single system clock; all logic on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port i_value, input, 14 bits: unsigned binary value to display.
REQ-005 The block SHALL have port i_load, input, 1 bit: capture strobe for i_value.
REQ-006 The block SHALL have port i_blank_en, input, 1 bit: leading-zero blanking enable.
REQ-007 The block SHALL have port o_bcd, output, 4 bits: BCD digit (0-9) for the downstream binary-to-segment decoder.
REQ-008 The block SHALL have port o_com, output, 4 bits: active-low, one-hot digit common select; bit 0 is the ones digit.
REQ-009 The block SHALL have port o_busy, output, 1 bit: high while a conversion is in progress.
REQ-010 The block SHALL have port o_done, output, 1 bit: one-cycle pulse when new digits take effect.

Function
REQ-011 The conversion FSM SHALL have the states IDLE, CONV and DONE, with the following transitions:
- IDLE -> CONV on i_load=1.
- CONV -> DONE after exactly 14 cycles.
- DONE -> IDLE after 1 cycle.
REQ-012 In IDLE with i_load=1, the block SHALL capture i_value, clamped to 9999 if i_value > 9999.
REQ-013 CONV SHALL perform a sequential shift-add-3 (double-dabble) conversion, one bit per cycle, MSB first, into four 4-bit BCD registers.
REQ-014 The output timing SHALL be as follows:
- o_busy is high in CONV and DONE only.
- o_done is high in DONE only.
- For i_load sampled at edge k, o_busy is high for cycles k+1..k+15 and o_done is high at cycle k+15.
REQ-015 The four display digit registers SHALL update atomically on the edge entering DONE, so new digits are first visible in the same cycle o_done is high; earlier display content is held unchanged during CONV.
REQ-016 The block SHALL ignore i_load while in CONV or DONE; no queuing.
REQ-017 The scan divider SHALL count 0..SCAN_DIV-1 and wrap to 0; at terminal count the scan index advances 0->1->2->3->0.
REQ-018 The scan output SHALL be registered as follows:
- o_com has only bit[index] low.
- o_bcd = display digit[index].
- Both change on the same edge.
REQ-019 Blanking SHALL apply only when i_blank_en=1: for index 1..3, if display digit[index] and all higher digits are 0, o_com = 4'b1111 for that slot while o_bcd = 0. The ones digit is never blanked.
REQ-020 i_blank_en SHALL take effect on the next scan-output update; no resynchronisation is required.
REQ-021 The scan SHALL run continuously, independent of the conversion FSM.
REQ-022 o_bcd SHALL never exceed 9.

Reset
REQ-023 While i_rst_n=0 at a rising edge, the block SHALL apply the following reset state on that edge:
- FSM -> IDLE.
- Divider, scan index, BCD working registers and display digits -> 0.
- o_bcd=4'd0, o_com=4'b1111, o_busy=0, o_done=0.
REQ-024 In the first cycle after reset release, o_com SHALL be 4'b1110 and o_bcd SHALL be 0.
REQ-025 Reset asserted during CONV or DONE SHALL abort the conversion; display digits SHALL read 0 and no o_done SHALL be produced.
REQ-026 An i_load coincident with an active reset SHALL be ignored.

Verification (SCAN_DIV=4)
REQ-027 Bench SHALL cover basic conversion: reset, then i_load with i_value=1234 -> o_busy high for 15 cycles, o_done high at load+15, then o_bcd sequence per scan slot 4,3,2,1 with o_com 1110,1101,1011,0111, each slot held 4 cycles.
REQ-028 Bench SHALL cover clamping: i_value=12000 -> digits 9,9,9,9.
REQ-029 Bench SHALL cover blanking: i_value=7 with i_blank_en=1 -> o_com 1110 with o_bcd=7, then 1111 for the three following slots; with i_blank_en=0, o_com walks all four slots with o_bcd=0 in slots 1..3.
REQ-030 Bench SHALL cover interior zeros: i_value=1005 with i_blank_en=1 -> digits 5,0,0,1, with no slot blanked.
REQ-031 Bench SHALL cover load during busy: i_load=4321, then i_load=1111 at load+5 -> one o_done only, display shows 4321.
REQ-032 Bench SHALL cover reset mid-operation: i_rst_n low at load+7 during CONV -> next cycle o_busy=0 and o_com=1111; after release, o_com=1110 with o_bcd=0 and no o_done pulse.
